// File: rtl/tff_pkg.sv
// Shared types and default constants for the push-button toggle conditioning path.
// The debounce state encoding and the parameter defaults live here so the bench can import them.
package tff_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } db_state_t;

    localparam int DB_CYCLES_DEF     = 4;
    localparam int REPEAT_DELAY_DEF  = 8;
    localparam int REPEAT_PERIOD_DEF = 4;

    // The shared counter must reach whichever terminal value is largest.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer; s1 may go metastable, s2 is the only stage used downstream.
// Both flops clear to 0 on a synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/tff_toggle_debounce.sv
// Turns a raw bouncing button level into one single-cycle toggle pulse per clean press.
// Optional auto-repeat while held is enabled by defining TFF_AUTOREPEAT_EN.
module tff_toggle_debounce
    import tff_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_pulse,
    output logic btn_level,
    output logic busy
);

    localparam int CNT_MAX = max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_TOP = cnt_t'(CNT_MAX);
    localparam cnt_t DB_LAST = cnt_t'(DB_CYCLES - 1);
`ifdef TFF_AUTOREPEAT_EN
    localparam cnt_t DELAY_LAST  = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t PERIOD_LAST = cnt_t'(REPEAT_PERIOD - 1);
`endif

    logic      btn_s;
    db_state_t state;
    db_state_t state_next;
    cnt_t      cnt;
    cnt_t      cnt_next;
    cnt_t      cnt_inc;
    logic      pulse_req;
`ifdef TFF_AUTOREPEAT_EN
    logic      rep_active;
    logic      rep_active_next;
`endif

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            t_pulse    <= 1'b0;
`ifdef TFF_AUTOREPEAT_EN
            rep_active <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            t_pulse    <= pulse_req & ~t_pulse;
`ifdef TFF_AUTOREPEAT_EN
            rep_active <= rep_active_next;
`endif
        end
    end

    // Saturating increment; every terminal value forces a transition before this matters.
    always_comb begin
        cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_req  = 1'b0;
`ifdef TFF_AUTOREPEAT_EN
        rep_active_next = rep_active;
`endif
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = DEB_PRESS;
                    cnt_next   = cnt_t'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    pulse_req  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = DEB_REL;
                    cnt_next   = cnt_t'(1);
`ifdef TFF_AUTOREPEAT_EN
                    rep_active_next = 1'b0;
`endif
                end else begin
`ifdef TFF_AUTOREPEAT_EN
                    // First repeat waits the long delay, later ones the shorter period.
                    if (cnt == (rep_active ? PERIOD_LAST : DELAY_LAST)) begin
                        pulse_req       = 1'b1;
                        cnt_next        = '0;
                        rep_active_next = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                    end
`else
                    cnt_next = '0;
`endif
                end
            end
            DEB_REL: begin
                if (btn_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        btn_level = (state == PRESSED) || (state == DEB_REL);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_tff_toggle_debounce.sv
// Directed bench for tff_toggle_debounce: expected pulse edges are queued when a press is driven
// and matched against t_pulse every cycle; a downstream T flip-flop q is modelled alongside.
module tb_tff_toggle_debounce;
    import tff_pkg::*;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic t_pulse;
    logic btn_level;
    logic busy;
    logic q;
    logic model_q = 1'b0;
    logic exp_t;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_seen = 0;
    int exp_pulse[$];
    int p;
    int seen_before;
    int exp_count;

    tff_toggle_debounce #(
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse),
        .btn_level (btn_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) q <= 1'b0;
        else if (t_pulse) q <= ~q;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h at edge %0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic btn_v, input int cycles);
        rst    = rst_v;
        btn_in = btn_v;
        repeat (cycles) @(negedge clk);
    endtask

    // Release from PRESSED: DEB_REL one cycle before the return to IDLE at release+2+DB.
    task automatic releaseAndCheck(input string tag);
        applyStimulus(1'b0, 1'b0, DB + 1);
        checkOutput({tag, "_busy_hold"}, 8'(busy), 8'd1);
        checkOutput({tag, "_level_hold"}, 8'(btn_level), 8'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput({tag, "_busy_idle"}, 8'(busy), 8'd0);
        checkOutput({tag, "_level_idle"}, 8'(btn_level), 8'd0);
    endtask

    // Scoreboard: t_pulse must be high exactly on the queued edges.
    always @(negedge clk) begin
        exp_t = (exp_pulse.size() > 0) && (exp_pulse[0] == cyc);
        if (exp_t) begin
            void'(exp_pulse.pop_front());
            model_q = ~model_q;
        end
        if (t_pulse === 1'b1) n_seen++;
        checkOutput("t_pulse", 8'(t_pulse), 8'(exp_t));
    end

    initial begin
        model_q = 1'b0;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("rst_t_pulse", 8'(t_pulse), 8'd0);
        checkOutput("rst_level", 8'(btn_level), 8'd0);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_state", 8'(dut.state), 8'(IDLE));
        checkOutput("rst_cnt", 8'(dut.cnt), 8'd0);

        exp_pulse.push_back(cyc + 2 + DB);
        applyStimulus(1'b0, 1'b1, DB + 1);
        checkOutput("rst_rel_level_pre", 8'(btn_level), 8'd0);
        checkOutput("rst_rel_busy_pre", 8'(busy), 8'd1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("rst_rel_level", 8'(btn_level), 8'd1);
        applyStimulus(1'b0, 1'b1, 2);
        releaseAndCheck("rst_rel");
        checkOutput("rst_rel_q", 8'(q), 8'(model_q));

        $display("[TB] clean press");
        exp_pulse.push_back(cyc + 2 + DB);
        applyStimulus(1'b0, 1'b1, DB + 1);
        checkOutput("press_level_pre", 8'(btn_level), 8'd0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("press_level", 8'(btn_level), 8'd1);
        checkOutput("press_state", 8'(dut.state), 8'(PRESSED));
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("press_q", 8'(q), 8'(model_q));
        releaseAndCheck("press_rel");

        $display("[TB] bounce");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'(i % 2 == 0), 2);
            checkOutput("bounce_level", 8'(btn_level), 8'd0);
        end
        exp_pulse.push_back(cyc + 2 + DB);
        applyStimulus(1'b0, 1'b1, DB + 2);
        checkOutput("bounce_level_held", 8'(btn_level), 8'd1);
        releaseAndCheck("bounce_rel");

        $display("[TB] press length boundary");
        applyStimulus(1'b0, 1'b1, DB - 1);
        applyStimulus(1'b0, 1'b0, DB + 4);
        checkOutput("short_busy", 8'(busy), 8'd0);
        checkOutput("short_level", 8'(btn_level), 8'd0);
        exp_pulse.push_back(cyc + 2 + DB);
        applyStimulus(1'b0, 1'b1, DB);
        applyStimulus(1'b0, 1'b0, DB + 6);
        checkOutput("exact_busy", 8'(busy), 8'd0);

        $display("[TB] release glitch");
        p = cyc + 2 + DB;
        exp_pulse.push_back(p);
        applyStimulus(1'b0, 1'b1, DB + 3);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("glitch_level_low", 8'(btn_level), 8'd1);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput("glitch_level", 8'(btn_level), 8'd1);
        end
        checkOutput("glitch_state", 8'(dut.state), 8'(PRESSED));
        releaseAndCheck("glitch_rel");

        $display("[TB] long hold");
        seen_before = n_seen;
        p = cyc + 2 + DB;
        exp_pulse.push_back(p);
        exp_count = 1;
`ifdef TFF_AUTOREPEAT_EN
        // Release at p+29 reaches DEB_REL at edge p+32, so repeats stop before that edge.
        for (int t = p + RD; t < p + 32; t += RP) begin
            exp_pulse.push_back(t);
            exp_count++;
        end
`endif
        applyStimulus(1'b0, 1'b1, p + 29 - cyc);
        releaseAndCheck("hold_rel");
        checkOutput("hold_count", 8'(n_seen - seen_before), 8'(exp_count));
        checkOutput("hold_q", 8'(q), 8'(model_q));

        $display("[TB] reset during debounce");
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("abort_state_pre", 8'(dut.state), 8'(DEB_PRESS));
        checkOutput("abort_cnt_pre", 8'(dut.cnt), 8'd2);
        model_q = 1'b0;
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("abort_t_pulse", 8'(t_pulse), 8'd0);
        checkOutput("abort_busy", 8'(busy), 8'd0);
        checkOutput("abort_level", 8'(btn_level), 8'd0);
        checkOutput("abort_cnt", 8'(dut.cnt), 8'd0);
        checkOutput("abort_state", 8'(dut.state), 8'(IDLE));
        exp_pulse.push_back(cyc + 2 + DB);
        applyStimulus(1'b0, 1'b1, DB + 3);
        checkOutput("abort_repress_level", 8'(btn_level), 8'd1);
        releaseAndCheck("abort_rel");
        checkOutput("abort_q", 8'(q), 8'(model_q));

        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("queue_drained", 8'(exp_pulse.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
